// File: rtl/mem_arb_pkg.sv
// Shared constants for the CPU memory-port arbiter: FSM state codes, timeout
// default and the control fields MEM/WB latches when a bubble is forced.
package mem_arb_pkg;

  localparam logic [1:0] stIdle   = 2'd0;
  localparam logic [1:0] stMeBusy = 2'd1;
  localparam logic [1:0] stIfBusy = 2'd2;
  localparam logic [1:0] stResp   = 2'd3;

  localparam int TIMEOUT_CYC_DEF = 64;

  // MEM/WB control fields while wb_bubble is high: nothing is written back.
  localparam logic BUBBLE_REG_WR     = 1'b0;
  localparam logic BUBBLE_MEM_TO_REG = 1'b0;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog for the memory port; only present when MEMARB_TIMEOUT_EN
// is defined. Counts while run is high and flags the CYC-th busy cycle.
`ifdef MEMARB_TIMEOUT_EN
module mem_arb_timer #(
  parameter int unsigned CYC = 64
)(
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(CYC + 1);

  logic [CW-1:0] cnt;

  // Leaving BUSY drops run, so every new access starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !run)
      cnt <= '0;
    else if (cnt != CW'(CYC - 1))
      cnt <= cnt + 1'b1;
  end

  assign expire = run && (cnt == CW'(CYC - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter/sequencer for IF and MEM; MEM wins ties.
// Optional busy-cycle timeout enabled by defining MEMARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          me_req,
  input  logic          me_we,
  input  logic [AW-1:0] me_addr,
  input  logic [DW-1:0] me_wdata,
  output logic [DW-1:0] me_rdata,
  output logic          me_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic          stall,
  output logic          wb_bubble,
  output logic          err_timeout
);

  logic [1:0]    state;
  logic          ownerMe;
  logic          holdWe;
  logic [AW-1:0] holdAddr;
  logic [DW-1:0] holdWdata;
  logic          busy;
  logic          expire;
  logic          finish;
  logic [DW-1:0] rdataIn;

  assign busy = (state == stMeBusy) || (state == stIfBusy);

`ifdef MEMARB_TIMEOUT_EN
  mem_arb_timer #(.CYC(TIMEOUT_CYC)) uTimer (
    .clk    (clk),
    .rst    (rst),
    .run    (busy),
    .expire (expire)
  );

  logic errQ;
  // mem_rdy in the expiry cycle is a normal completion, not an error.
  always_ff @(posedge clk) begin
    if (rst)
      errQ <= 1'b0;
    else if (busy && expire && !mem_rdy)
      errQ <= 1'b1;
  end
  assign err_timeout = errQ;
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYC == 0);
  assign expire           = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  assign finish  = busy && (mem_rdy || expire);
  // An aborted access completes with zero data.
  assign rdataIn = mem_rdy ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= stIdle;
      ownerMe   <= 1'b0;
      holdWe    <= 1'b0;
      holdAddr  <= '0;
      holdWdata <= '0;
      if_rdata  <= '0;
      me_rdata  <= '0;
    end else begin
      case (state)
        stIdle: begin
          if (me_req) begin
            state     <= stMeBusy;
            ownerMe   <= 1'b1;
            holdWe    <= me_we;
            holdAddr  <= me_addr;
            holdWdata <= me_wdata;
          end else if (if_req) begin
            state    <= stIfBusy;
            ownerMe  <= 1'b0;
            holdWe   <= 1'b0;
            holdAddr <= if_addr;
          end
        end
        stMeBusy, stIfBusy: begin
          if (finish) begin
            state <= stResp;
            if (state == stIfBusy)
              if_rdata <= rdataIn;
            else if (!holdWe)
              me_rdata <= rdataIn;
          end
        end
        default: state <= stIdle;
      endcase
    end
  end

  assign mem_req   = busy;
  assign mem_we    = (state == stMeBusy) && holdWe;
  assign mem_addr  = holdAddr;
  assign mem_wdata = holdWdata;
  assign me_done   = (state == stResp) && ownerMe;
  assign if_done   = (state == stResp) && !ownerMe;

  // Drops in the done cycle so MEM/WB captures the completed access once.
  assign stall     = (me_req && !me_done) || (if_req && !if_done);
  assign wb_bubble = stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for fetch/arbitration,
// hand sequences for store, stall, reset-abandon and (optional) timeout.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TCYC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, me_req, me_we, mem_rdy;
  logic [31:0] if_addr, me_addr, me_wdata, mem_rdata;
  logic [31:0] if_rdata, me_rdata, mem_addr, mem_wdata;
  logic        if_done, me_done, mem_req, mem_we, stall, wb_bubble, err_timeout;

  int nCmp = 0;
  int nBad = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
    .me_rdata(me_rdata), .me_done(me_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .stall(stall), .wb_bubble(wb_bubble), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir; logic [31:0] ia;
    logic mr; logic [31:0] ma;
    logic rdy; logic [31:0] rd;
    logic xq; logic [31:0] xa;
    logic xid, xmd, xs;
    logic [31:0] xir, xmr;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic mr, logic [31:0] ma,
                              logic rdy, logic [31:0] rd, logic xq, logic [31:0] xa,
                              logic xid, logic xmd, logic xs, logic [31:0] xir,
                              logic [31:0] xmr);
    vec_t r;
    r.ir = ir; r.ia = ia; r.mr = mr; r.ma = ma; r.rdy = rdy; r.rd = rd;
    r.xq = xq; r.xa = xa; r.xid = xid; r.xmd = xmd; r.xs = xs; r.xir = xir; r.xmr = xmr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t v[15];
  int   dones, retires;
  logic [31:0] wbData;

  localparam logic [31:0] A  = 32'h0040_0000, D  = 32'h2008_0005;
  localparam logic [31:0] B  = 32'h0040_0004, BD = 32'h8C08_0000;
  localparam logic [31:0] L  = 32'h1001_0000, LD = 32'h1234_5678;

  initial begin
    //         ir ia  mr ma rdy rd            xq xa xid xmd xs xir xmr
    v[0]  = mk(1, A,  0, 0, 0, 0,            0, 0, 0, 0, 1, 0,  0);
    v[1]  = mk(1, A,  0, 0, 1, D,            1, A, 0, 0, 1, 0,  0);
    v[2]  = mk(1, A,  0, 0, 0, 0,            0, A, 1, 0, 0, D,  0);
    v[3]  = mk(0, 0,  0, 0, 0, 0,            0, A, 0, 0, 0, D,  0);
    v[4]  = mk(1, B,  1, L, 0, 0,            0, A, 0, 0, 1, D,  0);
    v[5]  = mk(1, B,  1, L, 0, 0,            1, L, 0, 0, 1, D,  0);
    v[6]  = mk(1, B,  1, L, 1, LD,           1, L, 0, 0, 1, D,  0);
    v[7]  = mk(1, B,  1, L, 0, 0,            0, L, 0, 1, 1, D,  LD);
    v[8]  = mk(1, B,  0, 0, 0, 0,            0, L, 0, 0, 1, D,  LD);
    v[9]  = mk(1, B,  0, 0, 0, 32'hDEADBEEF, 1, B, 0, 0, 1, D,  LD);
    v[10] = mk(1, B,  0, 0, 1, BD,           1, B, 0, 0, 1, D,  LD);
    v[11] = mk(1, B,  0, 0, 0, 0,            0, B, 1, 0, 0, BD, LD);
    v[12] = mk(0, 0,  0, 0, 0, 0,            0, B, 0, 0, 0, BD, LD);
    v[13] = mk(0, 0,  0, 0, 1, 32'hFFFFFFFF, 0, B, 0, 0, 0, BD, LD);
    v[14] = mk(0, 0,  0, 0, 0, 0,            0, B, 0, 0, 0, BD, LD);

    rst = 1'b1; if_req = 0; me_req = 0; me_we = 0; mem_rdy = 0;
    if_addr = 0; me_addr = 0; me_wdata = 0; mem_rdata = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst mem_req", mem_req, 0);     chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);   chk("rst mem_wdata", mem_wdata, 0);
    chk("rst if_done", if_done, 0);     chk("rst me_done", me_done, 0);
    chk("rst if_rdata", if_rdata, 0);   chk("rst me_rdata", me_rdata, 0);
    chk("rst err", err_timeout, 0);     chk("rst stall", stall, 0);
    tick(); rst = 1'b0;

    // Lone fetch, simultaneous request, stray mem_rdy in IDLE.
    for (int i = 0; i < 15; i++) begin
      tick();
      if_req = v[i].ir; if_addr = v[i].ia; me_req = v[i].mr; me_addr = v[i].ma;
      me_we = 0; me_wdata = 0; mem_rdy = v[i].rdy; mem_rdata = v[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d mem_req", i), mem_req, v[i].xq);
      chk($sformatf("v%0d mem_we", i), mem_we, 0);
      chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].xa);
      chk($sformatf("v%0d if_done", i), if_done, v[i].xid);
      chk($sformatf("v%0d me_done", i), me_done, v[i].xmd);
      chk($sformatf("v%0d stall", i), stall, v[i].xs);
      chk($sformatf("v%0d wb_bubble", i), wb_bubble, v[i].xs);
      chk($sformatf("v%0d if_rdata", i), if_rdata, v[i].xir);
      chk($sformatf("v%0d me_rdata", i), me_rdata, v[i].xmr);
      chk($sformatf("v%0d err", i), err_timeout, 0);
    end

    // Store, 3-cycle memory.
    tick(); me_req = 1; me_we = 1; me_addr = 32'h1001_0010; me_wdata = 32'hCAFE_F00D; mem_rdy = 0;
    dones = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        tick(); mem_rdy = (c == 3); mem_rdata = 32'h5A5A_5A5A;
        if (c == 5) begin me_req = 0; me_we = 0; end
      end
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        chk("st mem_req", mem_req, 1);     chk("st mem_we", mem_we, 1);
        chk("st mem_addr", mem_addr, 32'h1001_0010);
        chk("st mem_wdata", mem_wdata, 32'hCAFE_F00D);
      end
      if (c == 4) begin
        chk("st me_done", me_done, 1); chk("st stall", stall, 0);
      end
      chk("st me_rdata", me_rdata, LD);
      dones += int'(me_done);
    end
    chk("st done count", dones, 1);

    // Load with 4-cycle memory; MEM/WB negedge latch model.
    tick(); me_req = 1; me_we = 0; me_addr = 32'h1001_0020; mem_rdy = 0;
    retires = 0; wbData = 0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin
        tick(); mem_rdy = (c == 4); mem_rdata = (c == 4) ? 32'h0BAD_F00D : 32'h0;
      end
      @(negedge clk);
      chk($sformatf("ld stall c%0d", c), stall, (c < 5));
      chk($sformatf("ld wb_bubble c%0d", c), wb_bubble, (c < 5));
      if ((wb_bubble ? BUBBLE_REG_WR : 1'b1) && (wb_bubble ? BUBBLE_MEM_TO_REG : 1'b1)) begin
        retires++;
        wbData = me_rdata;
      end
    end
    tick(); me_req = 0; mem_rdy = 0;
    chk("ld retires", retires, 1);
    chk("ld wb data", wbData, 32'h0BAD_F00D);

`ifdef MEMARB_TIMEOUT_EN
    // No mem_rdy: abort after TCYC busy cycles.
    tick(); me_req = 1; me_addr = 32'h1001_0040; mem_rdy = 0;
    for (int c = 1; c <= TCYC + 1; c++) begin
      tick(); @(negedge clk);
      if (c <= TCYC) begin
        chk("to busy", mem_req, 1); chk("to early done", me_done, 0);
      end else begin
        chk("to done", me_done, 1); chk("to rdata", me_rdata, 0);
        chk("to err", err_timeout, 1);
      end
    end
    tick(); me_req = 0;
    @(negedge clk); chk("to err sticky", err_timeout, 1);
    tick(); @(negedge clk); chk("to err sticky2", err_timeout, 1);
`else
    // No mem_rdy: access waits indefinitely without error.
    tick(); me_req = 1; me_addr = 32'h1001_0040; mem_rdy = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(); mem_rdy = (c == 12); mem_rdata = 32'h0000_4444;
      @(negedge clk);
      chk("wait busy", mem_req, 1); chk("wait done", me_done, 0);
      chk("wait err", err_timeout, 0);
    end
    tick(); mem_rdy = 0;
    @(negedge clk); chk("wait fin", me_done, 1); chk("wait data", me_rdata, 32'h0000_4444);
    tick(); me_req = 0;
`endif

    // Reset mid-access, then a late mem_rdy.
    tick(); me_req = 1; me_we = 0; me_addr = 32'h1001_0030; mem_rdy = 0;
    tick(); rst = 1;
    @(negedge clk); chk("rm busy", mem_req, 1);
    tick(); rst = 0; me_req = 0; mem_rdy = 1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("rm mem_req", mem_req, 0);   chk("rm me_done", me_done, 0);
    chk("rm me_rdata", me_rdata, 0); chk("rm if_rdata", if_rdata, 0);
    chk("rm mem_addr", mem_addr, 0); chk("rm err", err_timeout, 0);
    tick(); mem_rdy = 0;
    @(negedge clk); chk("rm no done", me_done, 0); chk("rm rdata", me_rdata, 0);
    tick(); if_req = 1; if_addr = 32'h0040_0008;
    @(negedge clk); chk("rf stall", stall, 1);
    tick(); mem_rdy = 1; mem_rdata = 32'h0000_0013;
    @(negedge clk); chk("rf mem_addr", mem_addr, 32'h0040_0008); chk("rf mem_req", mem_req, 1);
    tick(); mem_rdy = 0;
    @(negedge clk); chk("rf done", if_done, 1); chk("rf rdata", if_rdata, 32'h0000_0013);
    tick(); if_req = 0;
    @(negedge clk); chk("rf done off", if_done, 0);

`ifdef MEMARB_TIMEOUT_EN
    // mem_rdy in the expiry cycle completes normally.
    tick(); me_req = 1; me_addr = 32'h1001_0050; mem_rdy = 0;
    for (int c = 1; c <= TCYC + 1; c++) begin
      tick(); mem_rdy = (c == TCYC); mem_rdata = 32'h7777_7777;
      @(negedge clk);
      if (c == TCYC + 1) begin
        chk("tr done", me_done, 1); chk("tr rdata", me_rdata, 32'h7777_7777);
        chk("tr err", err_timeout, 0);
      end
    end
    tick(); me_req = 0; mem_rdy = 0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter/sequencer for the single shared memory port of the pipelined CPU. Grants the port to either instruction fetch (IF) or the MEM stage (load/store), sequences each variable-latency access with a req/rdy handshake, and drives the pipeline stall plus the bubble that keeps the MEM/WB register from retiring an instruction twice while the port is busy.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYC, 64, max busy cycles before abort (used only with MEMARB_TIMEOUT_EN)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word, registered
- if_done  out  1  one-cycle completion pulse
- me_req  in  1  MEM-stage request, held until me_done
- me_we  in  1  1 = store
- me_addr  in  AW  data address
- me_wdata  in  DW  store data
- me_rdata  out  DW  load data, registered, held until next ME load
- me_done  out  1  one-cycle completion pulse
- mem_req  out  1  port request
- mem_we  out  1  port write enable
- mem_addr  out  AW  port address
- mem_wdata  out  DW  port write data
- mem_rdata  in  DW  port read data, valid with mem_rdy
- mem_rdy  in  1  port completion
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- wb_bubble  out  1  force MEM/WB to latch a bubble (RegWr=0, MentoReg=0)
- err_timeout  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ME_BUSY, IF_BUSY, RESP.
- IDLE: me_req → capture me_addr/me_we/me_wdata into hold regs, go ME_BUSY; else if_req → capture if_addr, go IF_BUSY; else stay. Both requesting: ME wins (older instruction).
- ME_BUSY/IF_BUSY: mem_req=1, mem_* driven from hold regs (stable for whole access). On mem_rdy: capture mem_rdata into requester's rdata reg (loads and fetches only; stores leave me_rdata unchanged), go RESP.
- RESP: assert owner's done for exactly this cycle, mem_req=0, go IDLE. Requester deasserts req on sampling done.
- mem_rdy outside BUSY states is ignored.
- stall = (me_req & ~me_done) | (if_req & ~if_done), combinational.
- wb_bubble = stall.
- Reset values: state IDLE; mem_req, mem_we, if_done, me_done, err_timeout = 0; mem_addr, mem_wdata, if_rdata, me_rdata, hold regs = 0.
- Reset mid-access: transaction abandoned, no done pulse, any later mem_rdy ignored until a new BUSY.

## Timing
- Request sampled in IDLE at edge E0; mem_req high from E0 to edge where mem_rdy sampled; done high the following cycle.
- Minimum latency: req cycle 0, mem_rdy in cycle 1, done in cycle 2.
- Back-to-back: one IDLE cycle after RESP before next grant.
- stall drops combinationally in done cycle, so MEM/WB (negedge latch) captures valid me_rdata in that cycle.

## Configuration
- MEMARB_TIMEOUT_EN defined: busy-cycle counter cleared on BUSY entry; if TIMEOUT_CYC busy cycles elapse without mem_rdy, go RESP with done pulse, rdata reg loaded with 0, err_timeout set (sticky until rst). mem_rdy in the expiry cycle wins: normal completion, no error.
- Not defined: no counter, err_timeout tied 0, BUSY waits indefinitely.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ME_BUSY, IF_BUSY, RESP), TIMEOUT_CYC default, bubble control-field constants.
- Sub-module mem_arb_timer (busy-cycle counter + expiry), instantiated only under MEMARB_TIMEOUT_EN.

## Test plan
- Lone fetch: if_req, if_addr=0x0040_0000, mem_rdy 1 cycle later with 0x2008_0005 → if_done in cycle 2, if_rdata=0x2008_0005, stall high cycles 0–1.
- Simultaneous: if_req and me_req (load 0x1001_0000) in IDLE → ME served first, IF granted after one IDLE cycle; me_rdata stable while IF in flight.
- Store: me_we=1, me_wdata=0xCAFE_F00D, 3-cycle memory → mem_wdata/addr stable all busy cycles, me_rdata unchanged, single me_done.
- Stall/bubble: load with 4-cycle memory → stall and wb_bubble high until done cycle, MEM/WB retires load exactly once.
- Reset mid-access: rst during ME_BUSY, then mem_rdy → no done, outputs at reset values, next request served normally.
- MEMARB_TIMEOUT_EN, TIMEOUT_CYC=8, no mem_rdy → done after 8 busy cycles, rdata=0, err_timeout=1 until rst; mem_rdy on cycle 8 → no error.
